// File: rtl/sprite_pkg.sv
// Shared sprite types and defaults. The SPRITE_FLIP_EN macro adds a per-slot horizontal flip bit.
// Combinational helpers only. No flow control; every pixel is accepted.
package sprite_pkg;
    localparam int NUM_SPRITES_DEF = 4;
    localparam int SPR_W_DEF       = 20;
    localparam int SPR_H_DEF       = 20;
    localparam int SPR_ROM_AW      = 12;
    localparam int IDX_W_DEF       = 4;
    localparam int COORD_W         = 10;
    // One extra bit so that a pixel left of or above a sprite wraps to a large value instead of aliasing.
    localparam int DIFF_W          = COORD_W + 1;
    localparam int TRANSPARENT_IDX = 0;

    typedef struct packed {
        logic                    en;
        logic [COORD_W-1:0]      x;
        logic [COORD_W-1:0]      y;
        logic [SPR_ROM_AW-1:0]   base;
`ifdef SPRITE_FLIP_EN
        logic                    flip;
`endif
    } sprite_cfg_t;

    function automatic logic [DIFF_W-1:0] sprite_diff(input logic [COORD_W-1:0] a,
                                                      input logic [COORD_W-1:0] b);
        return {1'b0, a} - {1'b0, b};
    endfunction
endpackage

// File: rtl/sprite_prio_sel.sv
// Hit test and fixed-priority select over all slots; the lowest hitting slot wins.
// Purely combinational with zero latency and no backpressure.
module sprite_prio_sel
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = NUM_SPRITES_DEF,
    parameter int SPR_W       = SPR_W_DEF,
    parameter int SPR_H       = SPR_H_DEF,
    parameter int SLOT_W      = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  sprite_cfg_t [NUM_SPRITES-1:0] cfg,
    input  logic [COORD_W-1:0]            draw_x,
    input  logic [COORD_W-1:0]            draw_y,
    output logic                          hit,
    output logic [SLOT_W-1:0]             slot,
    output logic [DIFF_W-1:0]             off_x,
    output logic [DIFF_W-1:0]             off_y
);
    logic [DIFF_W-1:0] dx [NUM_SPRITES];
    logic [DIFF_W-1:0] dy [NUM_SPRITES];
    logic              slot_hit [NUM_SPRITES];

    always_comb begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
            dx[i]       = sprite_diff(draw_x, cfg[i].x);
            dy[i]       = sprite_diff(draw_y, cfg[i].y);
            slot_hit[i] = cfg[i].en && (dx[i] < DIFF_W'(SPR_W)) && (dy[i] < DIFF_W'(SPR_H));
        end
    end

    // Walk from the lowest priority upward so the lowest index overwrites last.
    always_comb begin
        hit   = 1'b0;
        slot  = '0;
        off_x = '0;
        off_y = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (slot_hit[i]) begin
                hit   = 1'b1;
                slot  = SLOT_W'(i);
                off_x = dx[i];
                off_y = dy[i];
            end
        end
    end
endmodule

// File: rtl/sprite_layer_sched.sv
// Per-pixel sprite scheduler sharing one ROM/palette; 3-cycle DrawX/DrawY-to-output latency; optional SPRITE_FLIP_EN.
// Free-running pixel pipeline with no backpressure; config is double-buffered and swapped on frame_start.
module sprite_layer_sched
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = NUM_SPRITES_DEF,
    parameter int SPR_W       = SPR_W_DEF,
    parameter int SPR_H       = SPR_H_DEF,
    parameter int ROM_AW      = SPR_ROM_AW,
    parameter int IDX_W       = IDX_W_DEF,
    parameter int SLOT_W      = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic                  vga_clk,
    input  logic                  reset_n,
    input  logic [COORD_W-1:0]    DrawX,
    input  logic [COORD_W-1:0]    DrawY,
    input  logic                  blank,
    input  logic                  frame_start,
    input  logic                  cfg_we,
    input  logic [SLOT_W-1:0]     cfg_idx,
    input  logic                  cfg_en,
    input  logic [COORD_W-1:0]    cfg_x,
    input  logic [COORD_W-1:0]    cfg_y,
    input  logic [ROM_AW-1:0]     cfg_base,
`ifdef SPRITE_FLIP_EN
    input  logic                  cfg_flip,
`endif
    output logic [ROM_AW-1:0]     rom_address,
    input  logic [IDX_W-1:0]      rom_q,
    output logic [IDX_W-1:0]      pal_index,
    output logic                  pix_hit,
    output logic                  pix_blank,
    output logic [SLOT_W-1:0]     busy_slot
);
    sprite_cfg_t [NUM_SPRITES-1:0] shadow_q, shadow_d;
    sprite_cfg_t [NUM_SPRITES-1:0] active_q, active_d;
    sprite_cfg_t                   cfg_wr;
    sprite_cfg_t                   sel_cfg;

    logic                sel_hit;
    logic [SLOT_W-1:0]   sel_slot;
    logic [DIFF_W-1:0]   sel_off_x;
    logic [DIFF_W-1:0]   sel_off_y;
    logic [DIFF_W-1:0]   col;

    logic [ROM_AW-1:0]   rom_address_q, rom_address_d;
    logic                hit1_q, hit1_d;
    logic [SLOT_W-1:0]   slot1_q, slot1_d;
    logic                blank1_q, blank1_d;
    logic                hit2_q, hit2_d;
    logic [SLOT_W-1:0]   slot2_q, slot2_d;
    logic                blank2_q, blank2_d;
    logic [IDX_W-1:0]    pal_index_q, pal_index_d;
    logic                pix_hit_q, pix_hit_d;
    logic                pix_blank_q, pix_blank_d;
    logic [SLOT_W-1:0]   busy_slot_q, busy_slot_d;

    // The active bank copies the pre-write shadow, so a write coinciding with frame_start waits a frame.
    always_comb begin
        cfg_wr      = '0;
        cfg_wr.en   = cfg_en;
        cfg_wr.x    = cfg_x;
        cfg_wr.y    = cfg_y;
        cfg_wr.base = SPR_ROM_AW'(cfg_base);
`ifdef SPRITE_FLIP_EN
        cfg_wr.flip = cfg_flip;
`endif
        shadow_d = shadow_q;
        if (cfg_we) begin
            shadow_d[cfg_idx] = cfg_wr;
        end
        active_d = frame_start ? shadow_q : active_q;
    end

    sprite_prio_sel #(
        .NUM_SPRITES (NUM_SPRITES),
        .SPR_W       (SPR_W),
        .SPR_H       (SPR_H),
        .SLOT_W      (SLOT_W)
    ) u_prio_sel (
        .cfg    (active_q),
        .draw_x (DrawX),
        .draw_y (DrawY),
        .hit    (sel_hit),
        .slot   (sel_slot),
        .off_x  (sel_off_x),
        .off_y  (sel_off_y)
    );

    always_comb begin
        sel_cfg = active_q[sel_slot];
        col     = sel_off_x;
`ifdef SPRITE_FLIP_EN
        if (sel_cfg.flip) begin
            col = DIFF_W'(SPR_W - 1) - sel_off_x;
        end
`endif
        rom_address_d = rom_address_q;
        if (sel_hit) begin
            rom_address_d = ROM_AW'(sel_cfg.base)
                          + ROM_AW'(32'(sel_off_y) * 32'(SPR_W))
                          + ROM_AW'(col);
        end
        hit1_d   = sel_hit;
        slot1_d  = sel_slot;
        blank1_d = blank;

        hit2_d   = hit1_q;
        slot2_d  = slot1_q;
        blank2_d = blank1_q;

        // Blanking forces the visible outputs low while the rest of the pipe keeps moving.
        pal_index_d = blank2_q ? rom_q : '0;
        pix_hit_d   = hit2_q && (rom_q != IDX_W'(TRANSPARENT_IDX)) && blank2_q;
        pix_blank_d = blank2_q;
        busy_slot_d = slot2_q;
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q      <= '0;
            active_q      <= '0;
            rom_address_q <= '0;
            hit1_q        <= 1'b0;
            slot1_q       <= '0;
            blank1_q      <= 1'b0;
            hit2_q        <= 1'b0;
            slot2_q       <= '0;
            blank2_q      <= 1'b0;
            pal_index_q   <= '0;
            pix_hit_q     <= 1'b0;
            pix_blank_q   <= 1'b0;
            busy_slot_q   <= '0;
        end else begin
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            rom_address_q <= rom_address_d;
            hit1_q        <= hit1_d;
            slot1_q       <= slot1_d;
            blank1_q      <= blank1_d;
            hit2_q        <= hit2_d;
            slot2_q       <= slot2_d;
            blank2_q      <= blank2_d;
            pal_index_q   <= pal_index_d;
            pix_hit_q     <= pix_hit_d;
            pix_blank_q   <= pix_blank_d;
            busy_slot_q   <= busy_slot_d;
        end
    end

    assign rom_address = rom_address_q;
    assign pal_index   = pal_index_q;
    assign pix_hit     = pix_hit_q;
    assign pix_blank   = pix_blank_q;
    assign busy_slot   = busy_slot_q;
endmodule
